dev_bridge_ctrl: RTL and testbench

//  Sequences CPU peripheral accesses (PrAddr/PrWD/PrWe/PrRD path) onto the device bus.

---
 rtl/bridge_pkg.sv | 19 +
 rtl/bridge_addr_decode.sv | 33 +++
 rtl/dev_bridge_ctrl.sv | 159 +++++++++++++++
 tb/tb_dev_bridge_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared constants, FSM state codes and read-data mux helper for the CPU-to-device bridge.
// Pure package: no timing or flow-control behaviour of its own.
package bridge_pkg;

  localparam int          MAX_DEV       = 6;
  localparam logic [31:0] BASE_ADDR_DEF = 32'h7F00;
  localparam logic [31:0] DEV_SPAN_DEF  = 32'h10;
  localparam logic [31:0] WIN_BYTES     = 32'hC;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic [31:0] dev_rd_sel(input logic [MAX_DEV*32-1:0] rd_bus,
                                             input logic [2:0]             idx);
    return rd_bus[32*idx +: 32];
  endfunction

endpackage

// File: rtl/bridge_addr_decode.sv
// Combinational byte-address decode to a one-hot device hit vector, hit index and miss flag.
// Zero latency; misaligned addresses and the unused 4th word of each window count as misses.
module bridge_addr_decode import bridge_pkg::*; #(
  parameter int          NDEV      = 2,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter logic [31:0] DEV_SPAN  = DEV_SPAN_DEF
) (
  input  logic [31:0]     addr,
  output logic [NDEV-1:0] hit,
  output logic [2:0]      idx,
  output logic            miss
);

  logic [31:0] off;
  logic [31:0] lo;

  always_comb begin
    off = addr - BASE_ADDR;
    lo  = '0;
    hit = '0;
    idx = '0;
    for (int i = 0; i < NDEV; i++) begin
      lo = 32'(i) * DEV_SPAN;
      // addr >= BASE_ADDR guards against off wrapping for addresses below the base
      if (addr[1:0] == 2'b00 && addr >= BASE_ADDR && off >= lo && off < lo + WIN_BYTES) begin
        hit[i] = 1'b1;
        idx    = 3'(i);
      end
    end
    miss = ~|hit;
  end

endmodule

// File: rtl/dev_bridge_ctrl.sv
// CPU peripheral bridge: decode, req/ack to one device, 1-cycle pr_ready (hit+ack: 2 cycles, miss: 1).
// CPU holds pr_req until pr_ready; BUSY waits on dev_ack, bounded only when BRIDGE_TIMEOUT_EN is defined.
module dev_bridge_ctrl import bridge_pkg::*; #(
  parameter int          NDEV      = 2,
  parameter logic [31:0] DEV_SPAN  = DEV_SPAN_DEF,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
`ifdef BRIDGE_TIMEOUT_EN
  , parameter int        TIMEOUT_CYC = 16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pr_req,
  input  logic [31:0]        pr_addr,
  input  logic [31:0]        pr_wd,
  input  logic               pr_we,
  output logic [31:0]        pr_rd,
  output logic               pr_ready,
  output logic               pr_err,
  output logic [NDEV-1:0]    dev_sel,
  output logic [1:0]         dev_addr,
  output logic [31:0]        dev_wd,
  output logic               dev_we,
  input  logic [NDEV*32-1:0] dev_rd,
  input  logic [NDEV-1:0]    dev_ack,
  input  logic [NDEV-1:0]    dev_irq,
  output logic [5:0]         hw_int
);

  logic [1:0]            state_q, state_d;
  logic [NDEV-1:0]       sel_q, sel_d;
  logic [2:0]            idx_q, idx_d;
  logic [1:0]            addr_q, addr_d;
  logic [31:0]           wd_q, wd_d;
  logic                  we_q, we_d;
  logic [31:0]           rd_q, rd_d;
  logic                  err_q, err_d;
  logic [5:0]            hw_int_q, hw_int_d;
  logic [NDEV-1:0]       dec_hit;
  logic [2:0]            dec_idx;
  logic                  dec_miss;
  logic [MAX_DEV*32-1:0] rd_pad;
  logic                  ack_sel;
  logic                  timeout;
`ifdef BRIDGE_TIMEOUT_EN
  logic [4:0]            cnt_q, cnt_d;
`endif

  bridge_addr_decode #(
    .NDEV      (NDEV),
    .BASE_ADDR (BASE_ADDR),
    .DEV_SPAN  (DEV_SPAN)
  ) u_decode (
    .addr (pr_addr),
    .hit  (dec_hit),
    .idx  (dec_idx),
    .miss (dec_miss)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    we_d     = we_q;
    rd_d     = rd_q;
    err_d    = err_q;
    hw_int_d = '0;
    hw_int_d[NDEV-1:0] = dev_irq;
    rd_pad   = '0;
    rd_pad[NDEV*32-1:0] = dev_rd;
    ack_sel  = |(dev_ack & sel_q);
`ifdef BRIDGE_TIMEOUT_EN
    // Cleared while idle so every BUSY entry starts counting from zero
    timeout = (state_q == ST_BUSY) && (cnt_q == 5'(TIMEOUT_CYC - 1));
    cnt_d   = (state_q == ST_IDLE) ? 5'd0 :
              (state_q == ST_BUSY) ? cnt_q + 5'd1 : cnt_q;
`else
    timeout = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pr_req) begin
          addr_d = pr_addr[3:2];
          wd_d   = pr_wd;
          we_d   = pr_we;
          rd_d   = '0;
          if (dec_miss) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            sel_d   = dec_hit;
            idx_d   = dec_idx;
            err_d   = 1'b0;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        // A simultaneous ack wins over the timeout
        if (ack_sel) begin
          rd_d    = we_q ? 32'h0 : dev_rd_sel(rd_pad, idx_q);
          err_d   = 1'b0;
          sel_d   = '0;
          state_d = ST_RESP;
        end else if (timeout) begin
          rd_d    = '0;
          err_d   = 1'b1;
          sel_d   = '0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      wd_q     <= '0;
      we_q     <= 1'b0;
      rd_q     <= '0;
      err_q    <= 1'b0;
      hw_int_q <= '0;
`ifdef BRIDGE_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      hw_int_q <= hw_int_d;
`ifdef BRIDGE_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign pr_ready = (state_q == ST_RESP);
  assign pr_rd    = pr_ready ? rd_q : 32'h0;
  assign pr_err   = pr_ready & err_q;
  assign dev_sel  = sel_q;
  assign dev_addr = addr_q;
  assign dev_wd   = wd_q;
  assign dev_we   = we_q & (|sel_q);
  assign hw_int   = hw_int_q;

endmodule

// File: tb/tb_dev_bridge_ctrl.sv
// Randomized bench for dev_bridge_ctrl against a window-arithmetic reference model.
// Covers directed reads/writes/misses, reset mid-access, irq registering and (with BRIDGE_TIMEOUT_EN) timeouts.
module tb_dev_bridge_ctrl;

  localparam int          NDEV = 2;
  localparam logic [31:0] BASE = 32'h7F00;
  localparam logic [31:0] SPAN = 32'h10;
  localparam int          TO   = 16;

  logic               clk;
  logic               reset;
  logic               pr_req;
  logic [31:0]        pr_addr;
  logic [31:0]        pr_wd;
  logic               pr_we;
  logic [31:0]        pr_rd;
  logic               pr_ready;
  logic               pr_err;
  logic [NDEV-1:0]    dev_sel;
  logic [1:0]         dev_addr;
  logic [31:0]        dev_wd;
  logic               dev_we;
  logic [NDEV*32-1:0] dev_rd;
  logic [NDEV-1:0]    dev_ack;
  logic [NDEV-1:0]    dev_irq;
  logic [5:0]         hw_int;

  int              n_vec = 0;
  int              n_err = 0;
  bit              rand_irq = 1'b0;
  logic [NDEV-1:0] irq_prev;

  dev_bridge_ctrl #(
    .NDEV      (NDEV),
    .DEV_SPAN  (SPAN),
    .BASE_ADDR (BASE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pr_req   (pr_req),
    .pr_addr  (pr_addr),
    .pr_wd    (pr_wd),
    .pr_we    (pr_we),
    .pr_rd    (pr_rd),
    .pr_ready (pr_ready),
    .pr_err   (pr_err),
    .dev_sel  (dev_sel),
    .dev_addr (dev_addr),
    .dev_wd   (dev_wd),
    .dev_we   (dev_we),
    .dev_rd   (dev_rd),
    .dev_ack  (dev_ack),
    .dev_irq  (dev_irq),
    .hw_int   (hw_int)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; hw_int must show the irq level that was present at the edge.
  task automatic tick();
    irq_prev = dev_irq;
    @(posedge clk);
    @(negedge clk);
    check("hw_int", 32'(hw_int), 32'(irq_prev));
    if (rand_irq) dev_irq = NDEV'($urandom);
  endtask

  // Reference decode: device index for a byte address, -1 when no window claims it.
  function automatic int exp_idx(input logic [31:0] a);
    logic [31:0] off;
    logic [1:0]  lsb;
    lsb = a[1:0];
    if (a < BASE || lsb != 2'b00) return -1;
    off = a - BASE;
    if (off / SPAN >= NDEV) return -1;
    if (off % SPAN >= 32'd12) return -1;
    return int'(off / SPAN);
  endfunction

  // delay = BUSY cycles without ack before the acking cycle.
  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic we, input int delay);
    int              idx;
    int              n;
    int              exp_n;
    logic [31:0]     exp_rd;
    logic            exp_err;
    logic [NDEV-1:0] own;
    bit              got_rdy;
    bit              to;
    idx = exp_idx(a);
    own = (idx < 0) ? '0 : (NDEV'(1) << idx);
    to  = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
    if (idx >= 0 && delay >= TO) to = 1'b1;
`endif
    if (idx < 0) begin
      exp_n = 1; exp_rd = '0; exp_err = 1'b1;
    end else if (to) begin
      exp_n = TO + 1; exp_rd = '0; exp_err = 1'b1;
    end else begin
      exp_n = delay + 2; exp_rd = we ? 32'h0 : dev_rd[32*idx +: 32]; exp_err = 1'b0;
    end
    pr_req = 1'b1; pr_addr = a; pr_wd = wd; pr_we = we;
    got_rdy = 1'b0;
    n = 0;
    while (!got_rdy && n < 60) begin
      tick();
      n++;
      if (pr_ready) begin
        got_rdy = 1'b1;
      end else begin
        check("busy_sel", 32'(dev_sel), 32'(own));
        check("busy_addr", 32'(dev_addr), 32'(a[3:2]));
        check("busy_we", 32'(dev_we), 32'(we));
        if (we) check("busy_wd", dev_wd, wd);
        // Every other device acks constantly; only the selected one may complete
        if (!to && n - 1 == delay) dev_ack = own | ~own;
        else                       dev_ack = ~own;
      end
    end
    dev_ack = '0;
    pr_req  = 1'b0;
    if (!got_rdy) begin
      check("ready_timeout", 32'(got_rdy), 32'd1);
    end else begin
      check("latency", 32'(n), 32'(exp_n));
      check("pr_rd", pr_rd, exp_rd);
      check("pr_err", 32'(pr_err), 32'(exp_err));
      check("resp_sel", 32'(dev_sel), 32'd0);
      check("resp_we", 32'(dev_we), 32'd0);
      tick();
      check("ready_pulse", 32'(pr_ready), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] a;
    int          kind;
    int          delay;
    reset = 1'b0; pr_req = 1'b0; pr_addr = '0; pr_wd = '0; pr_we = 1'b0;
    dev_rd = '0; dev_ack = '0; dev_irq = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(pr_ready), 32'd0);
    check("rst_rd", pr_rd, 32'd0);
    check("rst_err", 32'(pr_err), 32'd0);
    check("rst_sel", 32'(dev_sel), 32'd0);
    check("rst_we", 32'(dev_we), 32'd0);
    check("rst_addr", 32'(dev_addr), 32'd0);
    check("rst_wd", dev_wd, 32'd0);
    check("rst_hw_int", 32'(hw_int), 32'd0);
    reset = 1'b1;
    tick();

    dev_rd = {32'hCAFE_0001, 32'h0000_1234};
    access(32'h7F04, 32'h0, 1'b0, 0);
    access(32'h7F18, 32'hA5, 1'b1, 3);
    access(32'h7F0C, 32'h0, 1'b0, 0);
    access(32'h8000, 32'h0, 1'b0, 0);
    access(32'h7F02, 32'h0, 1'b0, 0);
    access(32'h7F18, 32'h0, 1'b0, 1);

    dev_irq = 2'b10;
    tick();
    check("irq_dir", 32'(hw_int), 32'h02);
    rand_irq = 1'b1;
    access(32'h7F10, 32'h5A, 1'b1, 2);

`ifdef BRIDGE_TIMEOUT_EN
    access(32'h7F00, 32'h0, 1'b0, TO + 4);
    access(32'h7F14, 32'h0, 1'b0, TO - 1);
`endif

    pr_req = 1'b1; pr_addr = 32'h7F10; pr_we = 1'b0;
    tick();
    tick();
    check("pre_rst_sel", 32'(dev_sel), 32'h2);
    reset = 1'b0;
    #1;
    check("mid_rst_sel", 32'(dev_sel), 32'd0);
    check("mid_rst_ready", 32'(pr_ready), 32'd0);
    check("mid_rst_hw_int", 32'(hw_int), 32'd0);
    pr_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("post_rst_ready", 32'(pr_ready), 32'd0);
    tick();
    check("post_rst_ready2", 32'(pr_ready), 32'd0);
    dev_rd = {32'h1111_2222, 32'h3333_4444};
    access(32'h7F00, 32'h0, 1'b0, 0);

    for (int k = 0; k < 150; k++) begin
      kind  = $urandom_range(0, 9);
      delay = $urandom_range(0, 5);
      dev_rd = {$urandom, $urandom};
      case (kind)
        6:       a = BASE + 32'($urandom_range(0, NDEV - 1)) * SPAN + 32'hC;
        7:       a = BASE + 32'($urandom_range(0, NDEV - 1)) * SPAN + 32'($urandom_range(1, 11));
        8:       a = $urandom;
        9:       a = ($urandom_range(0, 1) == 0) ? BASE - 32'd4 : BASE + 32'(NDEV) * SPAN;
        default: a = BASE + 32'($urandom_range(0, NDEV - 1)) * SPAN + 32'($urandom_range(0, 2)) * 32'd4;
      endcase
`ifdef BRIDGE_TIMEOUT_EN
      if ($urandom_range(0, 7) == 0) delay = $urandom_range(TO - 2, TO + 2);
`endif
      access(a, $urandom, 1'($urandom_range(0, 1)), delay);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
